// File: rtl/alu_cmd_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : alu_cmd_driver
//  Purpose  : Initiator side of the 8-bit ALU operand/result interface.
//             Buffers incoming commands in a FIFO, drives a combinational ALU
//             with {accumulator, operand, opcode}, writes the ALU result (or a
//             direct load value) back into the accumulator, and returns every
//             result over a valid/ready response channel.
//  Ports    : clk, reset             - clock, synchronous active-high reset
//             cmd_valid_i/ready_o    - command handshake (ready = FIFO not full)
//             cmd_ld_i/op_i/data_i   - command payload
//             alu_a_o/b_o/op_o       - ALU operand and opcode outputs
//             alu_res_i              - combinational ALU result
//             res_valid_o/ready_i    - response handshake
//             res_data_o             - new accumulator value of the command
//             acc_o                  - current accumulator
//             res_zero_o             - result-is-zero flag (ALU_ZERO_FLAG_EN)
//  Options  : define ALU_ZERO_FLAG_EN to add the res_zero_o output.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_driver #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] ACC_RESET  = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic       cmd_ld_i,
    input  logic [2:0] cmd_op_i,
    input  logic [7:0] cmd_data_i,
    output logic [7:0] alu_a_o,
    output logic [7:0] alu_b_o,
    output logic [2:0] alu_op_o,
    input  logic [7:0] alu_res_i,
    output logic       res_valid_o,
    input  logic       res_ready_i,
    output logic [7:0] res_data_o,
    output logic [7:0] acc_o
`ifdef ALU_ZERO_FLAG_EN
    ,
    output logic       res_zero_o
`endif
);

    localparam int               c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [c_PTR_W:0] c_DEPTH   = (c_PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [1:0]       c_ST_IDLE  = 2'd0;
    localparam logic [1:0]       c_ST_ISSUE = 2'd1;
    localparam logic [1:0]       c_ST_RESP  = 2'd2;

    // FIFO storage: {ld, op[2:0], data[7:0]}
    logic [11:0]        r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic [c_PTR_W:0]   w_count_nxt;
    logic               r_cmd_ready;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;

    logic               r_cmd_ld;
    logic [2:0]         r_cmd_op;
    logic [7:0]         r_cmd_data;
    logic [7:0]         r_acc;
    logic               r_res_valid;
    logic [7:0]         r_res_data;
`ifdef ALU_ZERO_FLAG_EN
    logic               r_res_zero;
`endif

    logic               w_push;
    logic               w_pop;
    logic               w_fifo_empty;
    logic [11:0]        w_head;
    logic [7:0]         w_result;

    assign w_push       = cmd_valid_i && r_cmd_ready;
    assign w_fifo_empty = (r_count == '0);
    assign w_head       = r_mem[r_rd_ptr];
    assign w_result     = r_cmd_ld ? r_cmd_data : alu_res_i;

    // ------------------------------------------------------------------
    // FIFO occupancy. Ready is registered from the next-cycle count so the
    // response ready never reaches cmd_ready_o combinationally.
    // ------------------------------------------------------------------
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_cmd_ready <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count     <= w_count_nxt;
            r_cmd_ready <= (w_count_nxt != c_DEPTH);
        end
    end

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_ld_i, cmd_op_i, cmd_data_i};
        end
    end

    // ------------------------------------------------------------------
    // Control FSM. Pops come only from the registered count, so a command
    // pushed this cycle cannot be popped before the next one.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                w_state_nxt = c_ST_RESP;
            end
            c_ST_RESP: begin
                if (res_ready_i) begin
                    if (!w_fifo_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = c_ST_ISSUE;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Command register, accumulator and response registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd_ld    <= 1'b0;
            r_cmd_op    <= 3'd0;
            r_cmd_data  <= 8'h00;
            r_acc       <= ACC_RESET;
            r_res_valid <= 1'b0;
            r_res_data  <= 8'h00;
`ifdef ALU_ZERO_FLAG_EN
            r_res_zero  <= 1'b0;
`endif
        end else begin
            if (w_pop) begin
                r_cmd_ld   <= w_head[11];
                r_cmd_op   <= w_head[10:8];
                r_cmd_data <= w_head[7:0];
            end
            if (r_state == c_ST_ISSUE) begin
                r_acc       <= w_result;
                r_res_data  <= w_result;
`ifdef ALU_ZERO_FLAG_EN
                r_res_zero  <= (w_result == 8'h00);
`endif
                r_res_valid <= 1'b1;
            end else if ((r_state == c_ST_RESP) && res_ready_i) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign cmd_ready_o = r_cmd_ready;
    assign alu_a_o     = r_acc;
    assign alu_b_o     = r_cmd_data;
    assign alu_op_o    = r_cmd_op;
    assign res_valid_o = r_res_valid;
    assign res_data_o  = r_res_data;
    assign acc_o       = r_acc;
`ifdef ALU_ZERO_FLAG_EN
    assign res_zero_o  = r_res_zero;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_alu_cmd_driver
//  Purpose  : Directed self-checking bench for alu_cmd_driver, with a small
//             combinational ALU model attached to the ALU ports.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_driver;

    localparam logic [7:0] c_ACC_RST = 8'hA5;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready_o;
    logic       cmd_ld;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic [7:0] alu_a_o;
    logic [7:0] alu_b_o;
    logic [2:0] alu_op_o;
    logic [7:0] w_alu_res;
    logic       res_valid_o;
    logic       res_ready;
    logic [7:0] res_data_o;
    logic [7:0] acc_o;
`ifdef ALU_ZERO_FLAG_EN
    logic       res_zero_o;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    alu_cmd_driver #(
        .FIFO_DEPTH (4),
        .ACC_RESET  (c_ACC_RST)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready_o),
        .cmd_ld_i    (cmd_ld),
        .cmd_op_i    (cmd_op),
        .cmd_data_i  (cmd_data),
        .alu_a_o     (alu_a_o),
        .alu_b_o     (alu_b_o),
        .alu_op_o    (alu_op_o),
        .alu_res_i   (w_alu_res),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready),
        .res_data_o  (res_data_o),
        .acc_o       (acc_o)
`ifdef ALU_ZERO_FLAG_EN
        ,
        .res_zero_o  (res_zero_o)
`endif
    );

    // Reference ALU: shift amounts use operand B[2:0].
    always_comb begin
        w_alu_res = 8'h00;
        case (alu_op_o)
            3'd0: w_alu_res = alu_a_o + alu_b_o;
            3'd1: w_alu_res = alu_a_o - alu_b_o;
            3'd2: w_alu_res = alu_a_o << alu_b_o[2:0];
            3'd3: w_alu_res = alu_a_o >> alu_b_o[2:0];
            3'd4: w_alu_res = alu_a_o & alu_b_o;
            3'd5: w_alu_res = alu_a_o | alu_b_o;
            3'd6: w_alu_res = alu_a_o ^ alu_b_o;
            3'd7: w_alu_res = {7'd0, (alu_a_o == alu_b_o)};
            default: w_alu_res = 8'h00;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic ld, input logic [2:0] op, input logic [7:0] d);
        int waitc;
        waitc     = 0;
        cmd_valid = 1'b1;
        cmd_ld    = ld;
        cmd_op    = op;
        cmd_data  = d;
        while (!cmd_ready_o && waitc < 50) begin
            step();
            waitc++;
        end
        chk("push_timeout", (waitc < 50), 1'b1);
        step();
        cmd_valid = 1'b0;
    endtask

    // Single command from an idle, empty driver, checked cycle by cycle.
    task automatic run_cmd(input string tag, input logic ld, input logic [2:0] op,
                           input logic [7:0] d, input logic [7:0] exp_a,
                           input logic [7:0] exp_res);
        res_ready = 1'b1;
        push_cmd(ld, op, d);
        chk({tag, "_pop_valid"}, res_valid_o, 1'b0);
        step();
        chk({tag, "_issue_valid"}, res_valid_o, 1'b0);
        chk({tag, "_alu_a"}, alu_a_o, exp_a);
        chk({tag, "_alu_b"}, alu_b_o, d);
        chk({tag, "_alu_op"}, alu_op_o, op);
        step();
        chk({tag, "_res_valid"}, res_valid_o, 1'b1);
        chk({tag, "_res_data"}, res_data_o, exp_res);
        chk({tag, "_acc"}, acc_o, exp_res);
        chk({tag, "_alu_a_after"}, alu_a_o, exp_res);
`ifdef ALU_ZERO_FLAG_EN
        chk({tag, "_zero"}, res_zero_o, (exp_res == 8'h00));
`endif
        step();
        chk({tag, "_idle_valid"}, res_valid_o, 1'b0);
    endtask

    // Collect n in-order responses first, first+1, ... spaced 2 cycles apart.
    task automatic drain(input string tag, input logic [7:0] first, input int n);
        int cyc;
        int last;
        int waitc;
        cyc       = 0;
        last      = 0;
        res_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            waitc = 0;
            while (!res_valid_o && waitc < 20) begin
                step();
                waitc++;
                cyc++;
            end
            chk({tag, "_resp_timeout"}, (waitc < 20), 1'b1);
            chk({tag, "_resp_data"}, res_data_o, first + k[7:0]);
            if (k > 0) begin
                chk({tag, "_resp_spacing"}, cyc - last, 2);
            end
            last = cyc;
            step();
            cyc++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_acc;
        int n_stale;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_ld    = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = 8'h00;
        res_ready = 1'b0;
        step();
        step();
        chk("rst_res_valid", res_valid_o, 1'b0);
        chk("rst_res_data", res_data_o, 8'h00);
        chk("rst_cmd_ready", cmd_ready_o, 1'b0);
        chk("rst_acc", acc_o, c_ACC_RST);
        chk("rst_alu_b", alu_b_o, 8'h00);
        reset = 1'b0;
        step();
        chk("rst_ready_rise", cmd_ready_o, 1'b1);

        // Load, arithmetic with wrap-around
        run_cmd("ld05", 1'b1, 3'd0, 8'h05, c_ACC_RST, 8'h05);
        run_cmd("add03", 1'b0, 3'd0, 8'h03, 8'h05, 8'h08);
        run_cmd("sub09", 1'b0, 3'd1, 8'h09, 8'h08, 8'hFF);

        // Shift, compare, XOR to zero
        run_cmd("ld81", 1'b1, 3'd0, 8'h81, 8'hFF, 8'h81);
        run_cmd("lsr01", 1'b0, 3'd3, 8'h01, 8'h81, 8'h40);
        run_cmd("eql40", 1'b0, 3'd7, 8'h40, 8'h40, 8'h01);
        run_cmd("xor01", 1'b0, 3'd6, 8'h01, 8'h01, 8'h00);
        run_cmd("sll03", 1'b1, 3'd2, 8'h03, 8'h00, 8'h03);
        run_cmd("sll2", 1'b0, 3'd2, 8'h02, 8'h03, 8'h0C);

        // Capacity: 8 offered with no response ready, 5 fit
        res_ready = 1'b0;
        n_acc     = 0;
        for (int i = 0; i < 8; i++) begin
            cmd_valid = 1'b1;
            cmd_ld    = 1'b1;
            cmd_op    = 3'd0;
            cmd_data  = 8'h10 + i[7:0];
            if (cmd_ready_o) begin
                n_acc++;
            end
            step();
        end
        cmd_valid = 1'b0;
        chk("cap_accepted", n_acc, 5);
        chk("cap_ready_low", cmd_ready_o, 1'b0);
        drain("cap", 8'h10, 5);
        chk("cap_ready_back", cmd_ready_o, 1'b1);

        // Simultaneous push and pop at occupancy FIFO_DEPTH-1
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1;
            cmd_ld    = 1'b1;
            cmd_data  = 8'h21 + i[7:0];
            chk("pp_fill_ready", cmd_ready_o, 1'b1);
            step();
        end
        chk("pp_resp_a", res_data_o, 8'h21);
        chk("pp_resp_a_valid", res_valid_o, 1'b1);
        cmd_data  = 8'h25;
        res_ready = 1'b1;
        step();
        chk("pp_ready_kept", cmd_ready_o, 1'b1);
        cmd_data  = 8'h26;
        res_ready = 1'b0;
        step();
        cmd_valid = 1'b0;
        chk("pp_full", cmd_ready_o, 1'b0);
        drain("pp", 8'h22, 5);
        chk("pp_ready_back", cmd_ready_o, 1'b1);

        // Reset in the middle of a pending response with 3 queued
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1;
            cmd_ld    = 1'b1;
            cmd_data  = 8'h31 + i[7:0];
            step();
        end
        cmd_valid = 1'b0;
        chk("mr_pending", res_valid_o, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mr_valid", res_valid_o, 1'b0);
        chk("mr_acc", acc_o, c_ACC_RST);
        chk("mr_data", res_data_o, 8'h00);
        chk("mr_ready", cmd_ready_o, 1'b0);
        res_ready = 1'b1;
        step();
        chk("mr_ready_rise", cmd_ready_o, 1'b1);
        n_stale = 0;
        for (int i = 0; i < 10; i++) begin
            if (res_valid_o) begin
                n_stale++;
            end
            step();
        end
        chk("mr_no_stale", n_stale, 0);
        chk("mr_acc_kept", acc_o, c_ACC_RST);
        run_cmd("mr_after", 1'b0, 3'd4, 8'h0F, c_ACC_RST, 8'h05);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
